// File: rtl/level_cost_accum.sv
// Sum-of-squares cost engine over 1..NUM_BLOCKS quantised 4x4 blocks, LANES squares per cycle.
// Optional macro LEVEL_COST_NZ_COUNT_EN adds an nz_count output (non-zero level count).
module level_cost_accum #(
  parameter int BIT_WIDTH  = 16,
  parameter int NUM_BLOCKS = 16,
  parameter int COEFS      = 16,
  parameter int LANES      = 4,
  parameter int SUM_WIDTH  = 32,
  localparam int NB_W      = $clog2(NUM_BLOCKS + 1),
  localparam int LVL_W     = BIT_WIDTH * COEFS * NUM_BLOCKS,
  localparam int NZ_W      = $clog2(NUM_BLOCKS * COEFS + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [NB_W-1:0]      num_blocks,
  input  logic [LVL_W-1:0]     levels,
  output logic                 busy,
  output logic                 done,
  output logic [SUM_WIDTH-1:0] sum,
`ifdef LEVEL_COST_NZ_COUNT_EN
  output logic [NZ_W-1:0]      nz_count,
`endif
  output logic                 sat
);

  localparam int BEATS_PER_BLOCK = COEFS / LANES;
  localparam int TOTAL_BEATS     = NUM_BLOCKS * BEATS_PER_BLOCK;
  localparam int K_W             = $clog2(TOTAL_BEATS + 1);
  localparam int PW              = 2 * BIT_WIDTH + $clog2(LANES);
  localparam int EW              = ((SUM_WIDTH > PW) ? SUM_WIDTH : PW) + 1;
  localparam int NZB_W           = $clog2(LANES + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state;
  logic [LVL_W-1:0] lvl_q;
  logic [K_W-1:0]   n_beats;
  logic [K_W-1:0]   k;
  logic [NB_W-1:0]  nb_clamp;
  logic [PW-1:0]    partial;
  logic [NZB_W-1:0] nz_beat;
  logic [EW-1:0]    sum_ext;
  logic             overflow;
  logic             last_beat;

  assign busy     = (state != S_IDLE);
  assign nb_clamp = (num_blocks > NB_W'(NUM_BLOCKS)) ? NB_W'(NUM_BLOCKS) : num_blocks;
  assign last_beat = (n_beats == '0) || (k == n_beats - 1'b1);

  // The capture register shifts down one beat per cycle, so the current lanes
  // always sit at the bottom and no wide read mux is needed.
  always_comb begin
    logic signed [BIT_WIDTH-1:0]   lane;
    logic signed [2*BIT_WIDTH-1:0] sq;
    // NOTE: every always_comb output gets a default before any conditional
    // path; otherwise synthesis infers a latch to hold the old value.
    partial = '0;
    nz_beat = '0;
    lane    = '0;
    sq      = '0;
    for (int l = 0; l < LANES; l++) begin
      lane    = lvl_q[l*BIT_WIDTH +: BIT_WIDTH];
      // A square is never negative and -2^(W-1) squared still fits, so the
      // signed product is reinterpreted as unsigned before widening.
      sq      = lane * lane;
      partial = partial + PW'($unsigned(sq));
      nz_beat = nz_beat + NZB_W'(lane != '0);
    end
    sum_ext  = {{(EW-SUM_WIDTH){1'b0}}, sum} + {{(EW-PW){1'b0}}, partial};
    overflow = |sum_ext[EW-1:SUM_WIDTH];
  end

  // NOTE: all state below is assigned with <= so every register samples the
  // pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      // NOTE: the capture register is wide but is still cleared on reset so
      // no stale levels from an aborted run survive into the next one.
      lvl_q   <= '0;
      n_beats <= '0;
      k       <= '0;
      sum     <= '0;
      sat     <= 1'b0;
      done    <= 1'b0;
`ifdef LEVEL_COST_NZ_COUNT_EN
      nz_count <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            lvl_q    <= levels;
            n_beats  <= K_W'(nb_clamp) * K_W'(BEATS_PER_BLOCK);
            k        <= '0;
            sum      <= '0;
            sat      <= 1'b0;
`ifdef LEVEL_COST_NZ_COUNT_EN
            nz_count <= '0;
`endif
            state    <= S_RUN;
          end
        end
        S_RUN: begin
          // A zero-block run is one empty beat: nothing is accumulated.
          if (n_beats != '0) begin
            if (overflow) begin
              sum <= '1;
              sat <= 1'b1;
            end else begin
              sum <= sum_ext[SUM_WIDTH-1:0];
            end
`ifdef LEVEL_COST_NZ_COUNT_EN
            nz_count <= nz_count + NZ_W'(nz_beat);
`endif
          end
          lvl_q <= lvl_q >> (LANES * BIT_WIDTH);
          k     <= k + 1'b1;
          if (last_beat) begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifndef LEVEL_COST_NZ_COUNT_EN
  logic unused_nz;
  assign unused_nz = ^nz_beat;
`endif

endmodule

// File: doc/level_cost_accum.md
Name: level_cost_accum

Overview:
Parametrised sum-of-squares cost engine for quantised coefficient levels. It computes sum(level^2) over a run-time selectable number of 4x4 blocks: 16 blocks for luma, 8 for chroma U/V. The engine processes LANES coefficients per cycle with signed levels and saturating accumulation. It sits after the quantiser in the mode-decision path and feeds the rate/distortion cost compare.

Parameters:
BIT_WIDTH, 16, width of one signed two's-complement level
NUM_BLOCKS, 16, maximum blocks held on the levels bus
COEFS, 16, coefficients per block (must be a multiple of LANES)
LANES, 4, coefficients squared and summed per cycle
SUM_WIDTH, 32, accumulator/output width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  request pulse; accepted only when idle
num_blocks  in  $clog2(NUM_BLOCKS+1)  blocks to process; sampled with start
levels  in  BIT_WIDTH*COEFS*NUM_BLOCKS  block b coef c at bits [(b*COEFS+c)*BIT_WIDTH +: BIT_WIDTH]; sampled with start
busy  out  1  high while state != IDLE
done  out  1  one-cycle pulse; sum/sat valid
sum  out  SUM_WIDTH  accumulated cost; held until next accepted start
sat  out  1  sticky: accumulator saturated during this run

Behaviour:
- Interface: clock clk; reset rst_n, asynchronous, active-low.
- Reset: state=IDLE; busy=0, done=0, sum=0, sat=0; internal beat counter and level capture register cleared. Reset mid-run aborts the run with no done pulse.
- States: IDLE -> RUN -> DONE -> IDLE.
- Accept: on edge T0 with start=1 and state=IDLE, the block does all of the following:
  - latches levels into an internal register, so the input may change after T0;
  - latches nb = min(num_blocks, NUM_BLOCKS);
  - clears sum and sat and beat counter k;
  - moves to RUN.
- start is ignored in RUN and DONE (no restart, no queueing).
- Beats: N = nb*COEFS/LANES.
  - On each RUN edge T1..TN, beat k adds the LANES squares of flat coefficients k*LANES .. k*LANES+LANES-1, then increments k.
  - Square: signed level x signed level, giving a 2*BIT_WIDTH unsigned result; the most-negative level squares correctly (-32768 -> 2^30).
  - Per-beat partial sum uses width 2*BIT_WIDTH+clog2(LANES) with no truncation.
- Saturation: if sum+partial >= 2^SUM_WIDTH, sum <= all ones and sat <= 1. Once saturated, sum stays all ones for the rest of the run.
- Completion:
  - On edge TN: state -> DONE and done <= 1.
  - On edge TN+1: done <= 0 and state -> IDLE.
  - A new start is accepted from edge TN+2 onward.
  - Latency from accept to done rising is N edges: 64 for 16 blocks, 32 for 8 blocks (LANES=4).
- nb=0: on T1 state -> DONE, done=1, sum=0, sat=0; behaves as a single empty beat.
- sum and sat update only on RUN beats and on accept; they are stable from done until the next accept.

Optional Feature:
Macro LEVEL_COST_NZ_COUNT_EN.
- Defined: adds output nz_count, width $clog2(NUM_BLOCKS*COEFS+1).
  - Counts coefficients with level != 0 over the same beats.
  - Cleared on accept, reset to 0, valid with done, held like sum.
  - It does not saturate (its width is sufficient).
- Undefined: the port and counter logic are absent; all other behaviour is identical.

Test Plan:
1. Defaults, num_blocks=8, all levels = 1, single start -> busy on next cycle; done exactly 32 edges after accept; sum=128, sat=0; done high for 1 cycle.
2. num_blocks=16, one level = -3 at block 15 coef 15, all others 0 -> done after 64 edges; sum=9 (nz_count=1 when enabled).
3. num_blocks=16, all levels = -32768 -> true total 2^38; sum=0xFFFFFFFF, sat=1 at done.
4. Then num_blocks=0 -> done 1 edge after accept; sum=0, sat=0 (sat cleared).
5. Start pulses every cycle during RUN and DONE, with levels changed after accept -> only the first start is taken; sum reflects the latched levels; exactly one done; next start accepted at TN+2.
6. Assert rst_n low at beat 10 of a run, release, then start num_blocks=2 with all levels = 2 -> no done from the aborted run; new run gives done after 8 edges and sum=128.
